// File: rtl/shot_scheduler.sv
// Round-robin launch scheduler: picks one requester and the lowest free projectile slot,
// pulses both for one frame, waits for the slot to go busy, then cools down.
module shot_scheduler #(
    parameter int NUM_REQ      = 8,
    parameter int NUM_SLOTS    = 15,
    parameter int MAX_INFLIGHT = 4,
    parameter int COOLDOWN     = 12,
    parameter int ACK_TIMEOUT  = 4,
    localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
    localparam int CW = $clog2(NUM_SLOTS + 1)
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    input  logic                 enable,
    input  logic [NUM_REQ-1:0]   Req,
    input  logic [NUM_SLOTS-1:0] SlotBusy,
    output logic [NUM_SLOTS-1:0] ShootSlot,
    output logic [NUM_REQ-1:0]   Grant,
    output logic [RW-1:0]        GrantIdx,
    output logic [SW-1:0]        SlotIdx,
    output logic [CW-1:0]        InFlight,
    output logic                 FireFault
);
    localparam int KW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam int AW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0]        MAX_IF    = CW'(MAX_INFLIGHT);
    localparam logic [KW-1:0]        COOL_LOAD = KW'(COOLDOWN - 1);
    localparam logic [AW-1:0]        ACK_LAST  = AW'(ACK_TIMEOUT - 1);
    localparam logic [RW-1:0]        REQ_LAST  = RW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0]   REQ_ONE   = NUM_REQ'(1);
    localparam logic [NUM_SLOTS-1:0] SLOT_ONE  = NUM_SLOTS'(1);

    typedef enum logic [2:0] {IDLE, ARB, FIRE, WAIT_ACK, COOL} state_e;

    state_e               state_q;
    logic [RW-1:0]        rr_ptr_q;
    logic [KW-1:0]        cool_cnt_q;
    logic [AW-1:0]        ack_cnt_q;
    logic [AW-1:0]        ack_cnt_d;
    logic [NUM_SLOTS-1:0] shoot_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [RW-1:0]        grant_idx_q;
    logic [SW-1:0]        slot_idx_q;
    logic [CW-1:0]        inflight_q;
    logic [CW-1:0]        inflight_d;
    logic                 fault_q;

    logic                 win_ok;
    logic [RW-1:0]        win_sel;
    logic                 slot_ok;
    logic [SW-1:0]        slot_sel;

    // Walk offsets from the far end so the nearest set bit at or after rr_ptr is kept.
    always_comb begin
        int j;
        j       = 0;
        win_ok  = 1'b0;
        win_sel = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = int'(rr_ptr_q) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (Req[RW'(j)]) begin
                win_ok  = 1'b1;
                win_sel = RW'(j);
            end
        end
    end

    always_comb begin
        slot_ok  = 1'b0;
        slot_sel = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!SlotBusy[SW'(i)]) begin
                slot_ok  = 1'b1;
                slot_sel = SW'(i);
            end
        end
    end

    always_comb begin
        inflight_d = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            inflight_d = inflight_d + CW'(SlotBusy[SW'(i)]);
    end

    assign ack_cnt_d = ack_cnt_q + 1'b1;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            cool_cnt_q  <= '0;
            ack_cnt_q   <= '0;
            shoot_q     <= '0;
            grant_q     <= '0;
            grant_idx_q <= '0;
            slot_idx_q  <= '0;
            inflight_q  <= '0;
            fault_q     <= 1'b0;
        end else begin
            shoot_q    <= '0;
            grant_q    <= '0;
            inflight_q <= inflight_d;
            case (state_q)
                IDLE: begin
                    if (enable && |Req && slot_ok && (inflight_q < MAX_IF))
                        state_q <= ARB;
                end
                ARB: begin
                    // Pulses are registered here so they are visible for the whole FIRE frame.
                    if (enable && win_ok && slot_ok) begin
                        grant_q     <= REQ_ONE << win_sel;
                        shoot_q     <= SLOT_ONE << slot_sel;
                        grant_idx_q <= win_sel;
                        slot_idx_q  <= slot_sel;
                        state_q     <= FIRE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                FIRE: begin
                    rr_ptr_q  <= (grant_idx_q == REQ_LAST) ? '0 : grant_idx_q + 1'b1;
                    ack_cnt_q <= '0;
                    state_q   <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (SlotBusy[slot_idx_q]) begin
                        cool_cnt_q <= COOL_LOAD;
                        state_q    <= COOL;
                    end else if (ack_cnt_d == ACK_LAST) begin
                        fault_q    <= 1'b1;
                        cool_cnt_q <= COOL_LOAD;
                        state_q    <= COOL;
                    end else begin
                        ack_cnt_q <= ack_cnt_d;
                    end
                end
                COOL: begin
                    if (cool_cnt_q == '0) state_q <= IDLE;
                    else                  cool_cnt_q <= cool_cnt_q - 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ShootSlot = shoot_q;
    assign Grant     = grant_q;
    assign GrantIdx  = grant_idx_q;
    assign SlotIdx   = slot_idx_q;
    assign InFlight  = inflight_q;
    assign FireFault = fault_q;
endmodule
